// File: rtl/jelly2_multi_interval_timer_pkg.sv
// Shared register map, CTL bit layout and byte-lane merge helper for the
// multi-channel interval timer.
package jelly2_multi_interval_timer_pkg;

  localparam logic [1:0] REG_CTL = 2'd0;
  localparam logic [1:0] REG_CMP = 2'd1;
  localparam logic [1:0] REG_CNT = 2'd2;
  localparam logic [1:0] REG_STS = 2'd3;

  localparam int CTL_EN       = 0;
  localparam int CTL_PERIODIC = 1;
  localparam int CTL_IE       = 2;
  localparam int CTL_CLR      = 3;

  localparam int STS_EXPIRED  = 0;

  localparam int BUS_W = 32;
  localparam int SEL_W = BUS_W / 8;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [BUS_W-1:0] wb_merge(
    input logic [BUS_W-1:0] old_v,
    input logic [BUS_W-1:0] new_v,
    input logic [SEL_W-1:0] sel
  );
    logic [BUS_W-1:0] res;
    for (int b = 0; b < SEL_W; b++) begin
      res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/jelly2_interval_timer_unit.sv
// One timer channel: CTL/CMP/CNT/STS registers, compare/expire logic and
// its slice of the bus read mux.
module jelly2_interval_timer_unit
  import jelly2_multi_interval_timer_pkg::*;
#(
  parameter int                       COUNTER_WIDTH = 32,
  parameter logic [COUNTER_WIDTH-1:0] CMP_INIT      = '0
) (
  input  logic              reset_n,
  input  logic              clk,
  input  logic              cke,
  input  logic              i_we,
  input  logic [1:0]        i_reg,
  input  logic [BUS_W-1:0]  i_wdat,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [BUS_W-1:0]  o_rdata,
  output logic              o_expire,
  output logic              o_irq
);

  logic                     r_en;
  logic                     r_periodic;
  logic                     r_ie;
  logic [COUNTER_WIDTH-1:0] r_cmp;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic                     r_sts;
  logic                     r_expire;

  logic                     w_wr_ctl;
  logic                     w_wr_cmp;
  logic                     w_wr_cnt;
  logic                     w_wr_sts;
  logic                     w_clr;
  logic                     w_count;
  logic                     w_expire;
  logic [BUS_W-1:0]         w_cmp_m;
  logic [BUS_W-1:0]         w_cnt_m;

  assign w_wr_ctl = i_we && (i_reg == REG_CTL);
  assign w_wr_cmp = i_we && (i_reg == REG_CMP);
  assign w_wr_cnt = i_we && (i_reg == REG_CNT);
  assign w_wr_sts = i_we && (i_reg == REG_STS);

  assign w_clr    = w_wr_ctl && i_sel[0] && i_wdat[CTL_CLR];

  // A bus load or clear of the counter pre-empts counting for that cycle.
  assign w_count  = r_en && cke && !w_wr_cnt && !w_clr;
  assign w_expire = w_count && (r_cnt >= r_cmp);

  assign w_cmp_m  = wb_merge(BUS_W'(r_cmp), i_wdat, i_sel);
  assign w_cnt_m  = wb_merge(BUS_W'(r_cnt), i_wdat, i_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_ie       <= 1'b0;
      r_cmp      <= CMP_INIT;
      r_cnt      <= '0;
      r_sts      <= 1'b0;
      r_expire   <= 1'b0;
    end else begin
      r_expire <= w_expire;

      // Bus write of CTL wins over the one-shot auto-disable.
      if (w_wr_ctl && i_sel[0]) begin
        r_en       <= i_wdat[CTL_EN];
        r_periodic <= i_wdat[CTL_PERIODIC];
        r_ie       <= i_wdat[CTL_IE];
      end else if (w_expire && !r_periodic) begin
        r_en       <= 1'b0;
      end

      if (w_wr_cmp) begin
        r_cmp <= w_cmp_m[COUNTER_WIDTH-1:0];
      end

      if (w_wr_cnt) begin
        r_cnt <= w_cnt_m[COUNTER_WIDTH-1:0];
      end else if (w_clr || w_expire) begin
        r_cnt <= '0;
      end else if (w_count) begin
        r_cnt <= r_cnt + COUNTER_WIDTH'(1);
      end

      // Expiry set has priority over write-1-to-clear.
      if (w_expire) begin
        r_sts <= 1'b1;
      end else if (w_wr_sts && i_sel[0] && i_wdat[STS_EXPIRED]) begin
        r_sts <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_CTL: begin
        o_rdata[CTL_EN]       = r_en;
        o_rdata[CTL_PERIODIC] = r_periodic;
        o_rdata[CTL_IE]       = r_ie;
      end
      REG_CMP: o_rdata = BUS_W'(r_cmp);
      REG_CNT: o_rdata = BUS_W'(r_cnt);
      default: o_rdata[STS_EXPIRED] = r_sts;
    endcase
  end

  assign o_expire = r_expire;
  assign o_irq    = r_sts && r_ie;

endmodule

// File: rtl/jelly2_multi_interval_timer.sv
// NUM_CH-channel interval timer on a zero-wait Wishbone slave: channel
// decode, read mux and interrupt OR around an array of timer units.
module jelly2_multi_interval_timer
  import jelly2_multi_interval_timer_pkg::*;
#(
  parameter int                       NUM_CH        = 4,
  parameter int                       WB_ADR_WIDTH  = 8,
  parameter int                       WB_DAT_WIDTH  = 32,
  parameter int                       COUNTER_WIDTH = 32,
  parameter logic [COUNTER_WIDTH-1:0] CMP_INIT      = '0
) (
  input  logic                      reset_n,
  input  logic                      clk,
  input  logic                      cke,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic [NUM_CH-1:0]         expire_pulse,
  output logic                      irq
);

  localparam int CH_W = WB_ADR_WIDTH - 2;

  logic [CH_W-1:0]              w_ch;
  logic [1:0]                   w_reg;
  logic [NUM_CH-1:0]            w_hit;
  logic [NUM_CH-1:0][BUS_W-1:0] w_rdata;
  logic [NUM_CH-1:0]            w_irq;
  logic [BUS_W-1:0]             w_rdat;

  assign w_ch  = s_wb_adr_i[WB_ADR_WIDTH-1:2];
  assign w_reg = s_wb_adr_i[1:0];

  // Channel numbers >= NUM_CH never hit, so they read 0 and drop writes.
  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_hit[g] = (w_ch == CH_W'(g));

      jelly2_interval_timer_unit #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .CMP_INIT      (CMP_INIT)
      ) u_unit (
        .reset_n  (reset_n),
        .clk      (clk),
        .cke      (cke),
        .i_we     (s_wb_stb_i && s_wb_we_i && w_hit[g]),
        .i_reg    (w_reg),
        .i_wdat   (s_wb_dat_i),
        .i_sel    (s_wb_sel_i),
        .o_rdata  (w_rdata[g]),
        .o_expire (expire_pulse[g]),
        .o_irq    (w_irq[g])
      );
    end
  endgenerate

  always_comb begin
    w_rdat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hit[i]) w_rdat = w_rdata[i];
    end
  end

  assign s_wb_dat_o = w_rdat;
  assign s_wb_ack_o = s_wb_stb_i && reset_n;
  assign irq        = |w_irq;

endmodule

// File: tb/tb_jelly2_multi_interval_timer.sv
// Scoreboard bench: bus reads push expected data, a negedge monitor pops and
// compares; pulse timing/counts and irq are checked against hand values.
module tb_jelly2_multi_interval_timer;

  logic        clk;
  logic        reset_n;
  logic        cke;
  logic [7:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic [3:0]  expire_pulse;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pcnt[4]  = '{default: 0};

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  jelly2_multi_interval_timer #(
    .NUM_CH        (4),
    .WB_ADR_WIDTH  (8),
    .WB_DAT_WIDTH  (32),
    .COUNTER_WIDTH (32),
    .CMP_INIT      (32'd7)
  ) dut (
    .reset_n      (reset_n),
    .clk          (clk),
    .cke          (cke),
    .s_wb_adr_i   (adr),
    .s_wb_dat_i   (dat_i),
    .s_wb_dat_o   (dat_o),
    .s_wb_we_i    (we),
    .s_wb_sel_i   (sel),
    .s_wb_stb_i   (stb),
    .s_wb_ack_o   (ack),
    .expire_pulse (expire_pulse),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (expire_pulse[i] === 1'b1) pcnt[i]++;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && stb && !we) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_read got=%h exp=none", dat_o);
      end else begin
        e = sb.pop_front();
        chk(e.name, dat_o, e.exp);
        chk({e.name, "_ack"}, 32'(ack), 32'd1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d,
                    input logic [3:0] s = 4'hF);
    @(posedge clk); #1;
    adr = 8'((ch << 2) | rg); dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
  endtask

  // Bus write landing exactly on edge index t.
  task automatic wr_at(input int t, input int ch, input int rg, input logic [31:0] d);
    idle(t - cyc - 2);
    wr(ch, rg, d);
  endtask

  task automatic rd(input int ch, input int rg, input logic [31:0] e, input string n);
    sb.push_back('{n, e});
    @(posedge clk); #1;
    adr = 8'((ch << 2) | rg); we = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic wait_pulse(input int ch, input int budget, output int at);
    at = -1;
    repeat (budget) begin
      @(negedge clk);
      if (expire_pulse[ch] === 1'b1) begin at = cyc; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, at, at2, at3, p;
    int ps[4];
    reset_n = 1'b0; cke = 1'b1; adr = '0; dat_i = '0; we = 1'b0; sel = 4'hF; stb = 1'b0;
    idle(3);
    reset_n = 1'b1;

    // reset mid-count
    wr(0, 1, 32'd100);
    wr(0, 0, 32'h3);
    idle(5);
    adr = 8'h02; stb = 1'b1;
    #1 chk("rst_precnt", dat_o, 32'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_cnt", dat_o, 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pulse", 32'(expire_pulse), 32'd0);
    adr = 8'h01;
    #1 chk("rst_cmp", dat_o, 32'd7);
    stb = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd(0, 0, 32'd0, "rst_rd_ctl");
    rd(0, 1, 32'd7, "rst_rd_cmp");
    rd(0, 2, 32'd0, "rst_rd_cnt");
    rd(0, 3, 32'd0, "rst_rd_sts");

    // periodic channel 0, CMP=9
    wr(0, 1, 32'd9);
    wr(0, 0, 32'h7);
    c0 = cyc;
    wait_pulse(0, 30, at);
    chk("per_first", 32'(at - c0), 32'd10);
    wait_pulse(0, 30, at2);
    chk("per_interval", 32'(at2 - at), 32'd10);
    rd(0, 3, 32'd1, "per_sts");
    chk("per_irq_set", 32'(irq), 32'd1);
    wr(0, 3, 32'd1);
    @(negedge clk);
    chk("per_irq_w1c", 32'(irq), 32'd0);
    wait_pulse(0, 20, at3);
    chk("per_interval2", 32'(at3 - at2), 32'd10);
    chk("per_irq_again", 32'(irq), 32'd1);
    wr(0, 0, 32'h0);
    wr(0, 3, 32'd1);
    @(negedge clk);
    chk("per_irq_off", 32'(irq), 32'd0);

    // one-shot channel 1, CMP=3
    p = pcnt[1];
    wr(1, 1, 32'd3);
    wr(1, 0, 32'h5);
    c0 = cyc;
    wait_pulse(1, 20, at);
    chk("os_delay", 32'(at - c0), 32'd4);
    idle(20);
    chk("os_count", 32'(pcnt[1] - p), 32'd1);
    rd(1, 0, 32'h4, "os_ctl");
    rd(1, 2, 32'd0, "os_cnt");
    wr(1, 3, 32'd1);
    rd(1, 3, 32'd0, "os_sts_clr");

    // collisions on channel 2, CMP=4 periodic
    wr(2, 1, 32'd4);
    wr(2, 0, 32'h3);
    c0 = cyc;
    p = pcnt[2];
    wr_at(c0 + 5, 2, 3, 32'd1);
    rd(2, 3, 32'd1, "col_w1c");
    wr_at(c0 + 10, 2, 2, 32'd100);
    cke = 1'b0;
    idle(2);
    chk("col_cnt_nopulse", 32'(pcnt[2] - p), 32'd1);
    rd(2, 2, 32'd100, "col_cnt");
    wr(2, 0, 32'h0);
    cke = 1'b1;
    wr(2, 3, 32'd1);

    // CMP lowered below CNT on channel 3
    cke = 1'b0;
    wr(3, 1, 32'd200);
    wr(3, 2, 32'd50);
    wr(3, 0, 32'h3);
    wr(3, 1, 32'd10);
    p = pcnt[3];
    idle(5);
    rd(3, 2, 32'd50, "low_hold");
    chk("low_nopulse", 32'(pcnt[3] - p), 32'd0);
    cke = 1'b1;
    idle(1);
    cke = 1'b0;
    idle(1);
    chk("low_pulse", 32'(pcnt[3] - p), 32'd1);
    rd(3, 2, 32'd0, "low_cnt");
    wr(3, 0, 32'h0);
    wr(3, 3, 32'd1);
    cke = 1'b1;

    // byte selects and out-of-range channel
    wr(1, 1, 32'h11223344);
    wr(1, 1, 32'hAABBCCDD, 4'b0001);
    rd(1, 1, 32'h112233DD, "bus_sel");
    wr(4, 1, 32'hFFFFFFFF);
    rd(4, 1, 32'd0, "bus_oob");
    rd(0, 1, 32'd9, "bus_oob_noalias");

    // all channels concurrently, periods 3/5/7/11
    cke = 1'b0;
    wr(0, 1, 32'd2);
    wr(1, 1, 32'd4);
    wr(2, 1, 32'd6);
    wr(3, 1, 32'd10);
    for (int i = 0; i < 4; i++) wr(i, 0, 32'hB);
    for (int i = 0; i < 4; i++) ps[i] = pcnt[i];
    cke = 1'b1;
    idle(1155);
    cke = 1'b0;
    idle(1);
    chk("multi_ch0", 32'(pcnt[0] - ps[0]), 32'd385);
    chk("multi_ch1", 32'(pcnt[1] - ps[1]), 32'd231);
    chk("multi_ch2", 32'(pcnt[2] - ps[2]), 32'd165);
    chk("multi_ch3", 32'(pcnt[3] - ps[3]), 32'd105);

    idle(2);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
